// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// request-sequencing states and the CAUSE word layout.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_MASK  = 2'd0;
  localparam logic [1:0] IRQ_EDGE  = 2'd1;
  localparam logic [1:0] IRQ_PEND  = 2'd2;
  localparam logic [1:0] IRQ_CAUSE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2,
    GAP  = 2'd3
  } irq_state_t;

  function automatic logic [31:0] irq_cause(input logic valid,
                                            input logic [15:0] cnt,
                                            input logic [4:0] id);
    return {valid, 7'b0, cnt, 3'b0, id};
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
// Purely combinational; no flow control.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [4:0]   id,
  output logic         any
);

  // Scanning downwards lets the lowest set index overwrite the others.
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 5'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller: sync, latch, mask and prioritise N_IRQ lines into CP0's single input.
// Latency: raw edge -> PENDING 3 clk, PENDING -> ir_req 1 clk; cfg reads are combinational.
// No backpressure: a request is held until CP0 pulses ir_taken, then until eret.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                N_IRQ    = 8,
  parameter logic [N_IRQ-1:0]  EDGE_RST = {N_IRQ{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             ie,
  output logic             ir_req,
  input  logic             ir_taken,
  input  logic             eret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata
);

  logic [N_IRQ-1:0] sync_1;
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] sync_d;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] edge_sel;
  logic [N_IRQ-1:0] pending;
  logic [4:0]       cur_id;
  logic [15:0]      svc_cnt;
  irq_state_t       state;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] svc_clr;
  logic [N_IRQ-1:0] pend_next;
  logic [4:0]       win_id;
  logic             win_any;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:N_IRQ];

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .req (pending & mask),
    .id  (win_id),
    .any (win_any)
  );

  // Edge sources: a fresh edge beats any same-cycle clear. Level sources mirror the line.
  always_comb begin
    rise    = sync & ~sync_d;
    w1c     = (cfg_we && cfg_addr == IRQ_PEND) ? cfg_wdata[N_IRQ-1:0] : '0;
    svc_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      svc_clr[i] = (state == REQ) && ir_taken && (cur_id == 5'(i));
    end
    pend_next = (edge_sel & ((pending & ~(w1c | svc_clr)) | rise))
              | (~edge_sel & sync);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1   <= '0;
      sync     <= '0;
      sync_d   <= '0;
      mask     <= '0;
      edge_sel <= EDGE_RST;
      pending  <= '0;
      cur_id   <= '0;
      svc_cnt  <= '0;
      state    <= IDLE;
      ir_req   <= 1'b0;
    end else begin
      sync_1  <= irq_src;
      sync    <= sync_1;
      sync_d  <= sync;
      pending <= pend_next;

      if (cfg_we && cfg_addr == IRQ_MASK) mask     <= cfg_wdata[N_IRQ-1:0];
      if (cfg_we && cfg_addr == IRQ_EDGE) edge_sel <= cfg_wdata[N_IRQ-1:0];

      // ir_req stays high through REQ and SVC so CP0 never sees a spurious edge.
      case (state)
        IDLE: begin
          if (ie && win_any) begin
            cur_id <= win_id;
            state  <= REQ;
            ir_req <= 1'b1;
          end
        end
        REQ: begin
          if (ir_taken) begin
            svc_cnt <= svc_cnt + 16'd1;
            state   <= SVC;
          end
        end
        SVC: begin
          if (eret) begin
            state  <= GAP;
            ir_req <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ir_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      IRQ_MASK:  cfg_rdata = 32'(mask);
      IRQ_EDGE:  cfg_rdata = 32'(edge_sel);
      IRQ_PEND:  cfg_rdata = 32'(pending);
      IRQ_CAUSE: cfg_rdata = irq_cause((state == REQ) || (state == SVC), svc_cnt, cur_id);
      default:   cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a delay-line/phase reference model.
module tb_irq_ctrl;

  localparam int N = 8;
  localparam int P_IDLE = 0, P_WAIT = 1, P_HANDLER = 2, P_GAP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic          ie;
  logic          ir_req;
  logic          ir_taken;
  logic          eret;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N_IRQ(N), .EDGE_RST(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .ie        (ie),
    .ir_req    (ir_req),
    .ir_taken  (ir_taken),
    .eret      (eret),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  // Reference model. d1/d2/d3 hold the raw lines seen 1/2/3 edges ago.
  logic [N-1:0] m_mask, m_edge, m_pend, d1, d2, d3;
  logic [4:0]   m_id;
  logic [15:0]  m_cnt;
  int           m_phase;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic valid;
    valid = (m_phase == P_WAIT) || (m_phase == P_HANDLER);
    case (a)
      2'd0:    return {24'b0, m_mask};
      2'd1:    return {24'b0, m_edge};
      2'd2:    return {24'b0, m_pend};
      default: return {valid, 7'b0, m_cnt, 3'b0, m_id};
    endcase
  endfunction

  task automatic model_edge();
    logic [N-1:0] lvl, rose, clr, nxt;
    int w;
    if (!rst) begin
      m_mask = '0; m_edge = '1; m_pend = '0; m_id = '0; m_cnt = '0;
      m_phase = P_IDLE; d1 = '0; d2 = '0; d3 = '0;
      return;
    end
    lvl  = d2;
    rose = d2 & ~d3;
    clr  = '0;
    if (cfg_we && cfg_addr == 2'd2) clr = cfg_wdata[N-1:0];
    for (int i = 0; i < N; i++)
      if (m_phase == P_WAIT && ir_taken && m_id == 5'(i)) clr[i] = 1'b1;
    for (int i = 0; i < N; i++)
      nxt[i] = m_edge[i] ? (rose[i] | (m_pend[i] & ~clr[i])) : lvl[i];
    w = lowest(m_pend & m_mask);
    case (m_phase)
      P_IDLE:    if (ie && w >= 0) begin m_id = 5'(w); m_phase = P_WAIT; end
      P_WAIT:    if (ir_taken) begin m_cnt = m_cnt + 16'd1; m_phase = P_HANDLER; end
      P_HANDLER: if (eret) m_phase = P_GAP;
      default:   m_phase = P_IDLE;
    endcase
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[N-1:0];
    if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[N-1:0];
    m_pend = nxt;
    d3 = d2; d2 = d1; d1 = irq_src;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic m_req;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    m_req = (m_phase == P_WAIT) || (m_phase == P_HANDLER);
    chk("ir_req", {31'b0, ir_req}, {31'b0, m_req});
    chk("cfg_rdata", cfg_rdata, model_read(cfg_addr));
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic service();
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b0; irq_src = '0; ie = 1'b0; ir_taken = 1'b0; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    tick(); tick();
    chk("rst_ir_req", {31'b0, ir_req}, 32'd0);
    rd("rst_mask", 2'd0, 32'h0);
    rd("rst_edge", 2'd1, 32'hFF);
    rd("rst_pend", 2'd2, 32'h0);
    rd("rst_cause", 2'd3, 32'h0);

    // 1: single edge source through request, service and ERET
    rst = 1'b1; ie = 1'b1;
    wr(2'd0, 32'h05);
    irq_src = 8'h04; tick(); irq_src = '0; tick(); tick();
    rd("t1_pend", 2'd2, 32'h04);
    chk("t1_noreq_yet", {31'b0, ir_req}, 32'd0);
    tick();
    chk("t1_req", {31'b0, ir_req}, 32'd1);
    rd("t1_cause", 2'd3, 32'h8000_0002);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    rd("t1_pend_clr", 2'd2, 32'h0);
    rd("t1_cause_svc", 2'd3, 32'h8000_0102);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("t1_gap", {31'b0, ir_req}, 32'd0);
    tick();
    chk("t1_idle", {31'b0, ir_req}, 32'd0);

    // 2: simultaneous edges, lowest index first
    irq_src = 8'h05; tick(); irq_src = '0; tick(); tick(); tick();
    rd("t2_first", 2'd3, 32'h8000_0100);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    tick(); tick();
    rd("t2_second", 2'd3, 32'h8000_0202);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    tick(); tick();

    // 3: pending while masked, gated by ie
    wr(2'd0, 32'h0);
    irq_src = 8'h02; tick(); irq_src = '0; tick(); tick();
    ie = 1'b0;
    wr(2'd0, 32'h02);
    tick();
    chk("t3_ie_off", {31'b0, ir_req}, 32'd0);
    ie = 1'b1; tick();
    chk("t3_ie_on", {31'b0, ir_req}, 32'd1);
    rd("t3_cause", 2'd3, 32'h8000_0301);
    service();

    // 4: level-mode source re-requests after GAP, W1C ignored
    wr(2'd1, 32'hF7);
    wr(2'd0, 32'h08);
    irq_src = 8'h08; tick(); tick(); tick(); tick();
    rd("t4_cause", 2'd3, 32'h8000_0403);
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    rd("t4_pend_level", 2'd2, 32'h08);
    wr(2'd2, 32'h08);
    rd("t4_w1c_ignored", 2'd2, 32'h08);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("t4_gap", {31'b0, ir_req}, 32'd0);
    tick(); tick();
    chk("t4_rereq", {31'b0, ir_req}, 32'd1);
    irq_src = '0; tick(); tick(); tick();
    rd("t4_pend_drop", 2'd2, 32'h0);
    chk("t4_no_withdraw", {31'b0, ir_req}, 32'd1);
    service();

    // 5: new edge and W1C in the same cycle while in service
    wr(2'd1, 32'hFF);
    wr(2'd0, 32'h10);
    irq_src = 8'h10; tick(); irq_src = '0; tick(); tick(); tick();
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;
    rd("t5_pend_svc", 2'd2, 32'h0);
    irq_src = 8'h10; tick(); irq_src = '0; tick();
    wr(2'd2, 32'h10);
    rd("t5_set_wins", 2'd2, 32'h10);
    eret = 1'b1; tick(); eret = 1'b0;
    tick(); tick();
    ir_taken = 1'b1; tick(); ir_taken = 1'b0;

    // 6: reset during service
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t6_ir_req", {31'b0, ir_req}, 32'd0);
    rd("t6_mask", 2'd0, 32'h0);
    rd("t6_pend", 2'd2, 32'h0);
    rd("t6_cause", 2'd3, 32'h0);
    eret = 1'b1; tick(); eret = 1'b0;
    chk("t6_eret_ignored", {31'b0, ir_req}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src[$urandom_range(0, N - 1)] ^= 1'b1;
      ie        = ($urandom_range(0, 3) != 0);
      ir_taken  = ($urandom_range(0, 2) == 0);
      eret      = ($urandom_range(0, 2) == 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      rst       = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
